// File: rtl/rs_cmd_seq.sv
// Command sequencer for the gated SR latch: debounces the raw set/clear requests and
// issues clean, mutually exclusive S/R pulses of fixed length, each followed by an idle gap.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no pulse in progress, ready to launch
// PULSE_S | S held high for PULSE_LEN clocks
// PULSE_R | R held high for PULSE_LEN clocks
// GAP     | S=R=0 for GAP_LEN clocks before the next launch
module rs_cmd_seq #(
  parameter int DEB_LEN   = 4,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 2,
  parameter int CNT_W     = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic SetIn,
  input  logic ClrIn,
  output logic S,
  output logic R,
  output logic Busy,
  output logic QExp,
  output logic Drop
);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_LEN - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);

  // Index 0 carries the set request, index 1 the clear request.
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       filt;
  logic [1:0]       filt_d;
  logic [CNT_W-1:0] deb_cnt [2];

  logic set_req;
  logic clr_req;
  logic has_req;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] tmr_nx;
  logic             pend_v;
  logic             pend_v_nx;
  logic             pend_clr;
  logic             pend_clr_nx;
  logic             qexp_nx;
  logic             drop_nx;

  assign raw = {ClrIn, SetIn};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1      <= '0;
      sync2      <= '0;
      filt       <= '0;
      filt_d     <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            filt[i]    <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign set_req = filt[0] & ~filt_d[0];
  assign clr_req = filt[1] & ~filt_d[1];
  assign has_req = set_req | clr_req;

  always_comb begin
    state_nx    = state;
    tmr_nx      = tmr;
    pend_v_nx   = pend_v;
    pend_clr_nx = pend_clr;
    qexp_nx     = QExp;
    drop_nx     = set_req & clr_req;

    // While busy, a new request lands in the slot; an occupied slot means something is lost.
    if (state != IDLE && has_req) begin
      drop_nx     = drop_nx | pend_v;
      pend_v_nx   = 1'b1;
      pend_clr_nx = clr_req;
    end

    case (state)
      IDLE: begin
        if (pend_v) begin
          state_nx    = pend_clr ? PULSE_R : PULSE_S;
          tmr_nx      = PULSE_LAST;
          pend_v_nx   = has_req;
          pend_clr_nx = clr_req;
        end else if (has_req) begin
          state_nx = clr_req ? PULSE_R : PULSE_S;
          tmr_nx   = PULSE_LAST;
        end
      end
      PULSE_S, PULSE_R: begin
        if (tmr == '0) begin
          state_nx = GAP;
          tmr_nx   = GAP_LAST;
          qexp_nx  = (state == PULSE_S);
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      GAP: begin
        if (tmr == '0) begin
          // Launch straight from the gap, including a request that arrived on this very edge.
          if (pend_v_nx) begin
            state_nx  = pend_clr_nx ? PULSE_R : PULSE_S;
            tmr_nx    = PULSE_LAST;
            pend_v_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      tmr      <= '0;
      pend_v   <= 1'b0;
      pend_clr <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      Busy     <= 1'b0;
      QExp     <= 1'b0;
      Drop     <= 1'b0;
    end else begin
      state    <= state_nx;
      tmr      <= tmr_nx;
      pend_v   <= pend_v_nx;
      pend_clr <= pend_clr_nx;
      S        <= (state_nx == PULSE_S);
      R        <= (state_nx == PULSE_R);
      Busy     <= (state_nx != IDLE);
      QExp     <= qexp_nx;
      Drop     <= drop_nx;
    end
  end

endmodule

// File: tb/tb_rs_cmd_seq.sv
// Bench for rs_cmd_seq: a table-driven latency check, directed multi-cycle scenarios,
// and a random run compared cycle by cycle against a timing-window reference model.
module tb_rs_cmd_seq;

  localparam int DEB = 4;
  localparam int PL  = 3;
  localparam int GL  = 2;

  logic Clk;
  logic Rst;
  logic SetIn;
  logic ClrIn;
  logic S;
  logic R;
  logic Busy;
  logic QExp;
  logic Drop;

  int errors = 0;
  int total  = 0;

  rs_cmd_seq #(.DEB_LEN(DEB), .PULSE_LEN(PL), .GAP_LEN(GL), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .SetIn(SetIn), .ClrIn(ClrIn),
    .S(S), .R(R), .Busy(Busy), .QExp(QExp), .Drop(Drop)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: input filtering by run length, commands tracked as time windows.
  int   m_t;
  logic m_d1 [2];
  logic m_d2 [2];
  logic m_filt [2];
  logic m_filt_prev [2];
  int   m_run [2];
  logic m_act;
  int   m_st;
  logic m_cmd_set;
  logic m_pv;
  logic m_pset;
  logic m_q;
  logic m_drop;

  task automatic model_edge(input logic rst_i, input logic set_i, input logic clr_i);
    logic req_s, req_c, has, drop, raw_i, sync_old;
    int end_t;
    m_t++;
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        m_d1[i] = 0; m_d2[i] = 0; m_filt[i] = 0; m_filt_prev[i] = 0; m_run[i] = 0;
      end
      m_act = 0; m_pv = 0; m_pset = 0; m_q = 0; m_drop = 0; m_cmd_set = 0; m_st = 0;
      return;
    end
    req_s = m_filt[0] & ~m_filt_prev[0];
    req_c = m_filt[1] & ~m_filt_prev[1];
    has   = req_s | req_c;
    drop  = req_s & req_c;
    end_t = m_st + PL + GL;
    if (m_act && m_t <= end_t) begin
      if (m_t == m_st + PL) m_q = m_cmd_set;
      if (has) begin
        if (m_pv) drop = 1;
        m_pv   = 1;
        m_pset = ~req_c;
      end
      if (m_t == end_t) begin
        if (m_pv) begin
          m_st = m_t; m_cmd_set = m_pset; m_pv = 0;
        end else begin
          m_act = 0;
        end
      end
    end else begin
      m_act = 0;
      if (has) begin
        m_act = 1; m_st = m_t; m_cmd_set = ~req_c;
      end
    end
    m_drop = drop;
    for (int i = 0; i < 2; i++) begin
      raw_i = (i == 0) ? set_i : clr_i;
      sync_old = m_d2[i];
      m_filt_prev[i] = m_filt[i];
      if (sync_old != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_filt[i] = sync_old;
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_d2[i] = m_d1[i];
      m_d1[i] = raw_i;
    end
  endtask

  function automatic logic [4:0] model_out();
    logic s, r, b;
    b = m_act && (m_t < m_st + PL + GL);
    s = m_act && m_cmd_set && (m_t < m_st + PL);
    r = m_act && !m_cmd_set && (m_t < m_st + PL);
    return {s, r, b, m_q, m_drop};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic rst_i, input logic set_i, input logic clr_i);
    @(negedge Clk);
    Rst = rst_i; SetIn = set_i; ClrIn = clr_i;
    @(posedge Clk);
    model_edge(rst_i, set_i, clr_i);
    #1;
    chk("model {S,R,Busy,QExp,Drop}", int'({S, R, Busy, QExp, Drop}), int'(model_out()));
    chk("s_and_r_exclusive", int'(S & R), 0);
  endtask

  logic [63:0] obs_s, obs_r, obs_b, obs_q, obs_d;

  task automatic run_pat(input logic [63:0] sp, input logic [63:0] cp,
                         input logic [63:0] rp, input int ncyc);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    obs_s = '0; obs_r = '0; obs_b = '0; obs_q = '0; obs_d = '0;
    for (int n = 1; n <= ncyc; n++) begin
      step(rp[n], sp[n], cp[n]);
      obs_s[n] = S; obs_r[n] = R; obs_b[n] = Busy; obs_q[n] = QExp; obs_d[n] = Drop;
    end
  endtask

  function automatic logic [63:0] mask(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int first_rise(input logic [63:0] v, input int from);
    for (int n = from + 1; n < 64; n++)
      if (v[n] && !v[n-1]) return n;
    return -1;
  endfunction

  function automatic int rises(input logic [63:0] v);
    return $countones(v & ~(v << 1));
  endfunction

  typedef struct {
    logic       rst;
    logic       set;
    logic       clr;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [17];
  logic [63:0] sp, cp, rp;
  logic lvl_s, lvl_c, gs, gc, rr;

  initial begin
    Rst = 1'b1; SetIn = 1'b0; ClrIn = 1'b0;
    m_t = 0;
    model_edge(1'b1, 1'b0, 1'b0);

    // Scenario 1 as a table: 3 reset clocks, then SetIn held high.
    for (int i = 0; i < 3; i++) begin
      tbl[i].rst = 1; tbl[i].set = 0; tbl[i].clr = 0; tbl[i].exp = 5'b00000;
    end
    for (int k = 1; k <= 14; k++) begin
      tbl[k+2].rst = 0; tbl[k+2].set = 1; tbl[k+2].clr = 0;
      tbl[k+2].exp = {(k >= 7 && k <= 9), 1'b0, (k >= 7 && k <= 11), (k >= 10), 1'b0};
    end
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].set, tbl[i].clr);
      chk($sformatf("table[%0d] {S,R,Busy,QExp,Drop}", i),
          int'({S, R, Busy, QExp, Drop}), int'(tbl[i].exp));
    end

    // Scenario 2: bouncing set input never qualifies.
    sp = '0;
    for (int n = 1; n <= 10; n += 2) sp[n] = 1'b1;
    run_pat(sp, 64'd0, 64'd0, 30);
    chk("bounce S highs", $countones(obs_s), 0);
    chk("bounce R highs", $countones(obs_r), 0);
    chk("bounce Drop", $countones(obs_d), 0);
    chk("bounce QExp", int'(obs_q[30]), 0);

    // Scenario 3: simultaneous set and clear, clear wins.
    sp = mask(1, 40);
    run_pat(sp, sp, 64'd0, 25);
    chk("simul R rise", first_rise(obs_r, 0), 7);
    chk("simul R width", $countones(obs_r), PL);
    chk("simul S highs", $countones(obs_s), 0);
    chk("simul Drop count", $countones(obs_d), 1);
    chk("simul QExp", int'(obs_q[25]), 0);

    // Scenario 4: clear queued during S pulse launches straight out of the gap.
    run_pat(mask(1, 40), mask(3, 40), 64'd0, 25);
    chk("queued S rise", first_rise(obs_s, 0), 7);
    chk("queued R rise", first_rise(obs_r, 0), 7 + PL + GL);
    chk("queued busy cycles", $countones(obs_b), 2 * (PL + GL));
    chk("queued QExp mid", int'(obs_q[10]), 1);
    chk("queued QExp end", int'(obs_q[25]), 0);
    chk("queued Drop", $countones(obs_d), 0);

    // Scenario 5: set then clear both queued during a busy period, clear overwrites.
    sp = mask(1, 4) | mask(9, 40);
    cp = mask(2, 5) | mask(10, 40);
    run_pat(sp, cp, 64'd0, 30);
    chk("overwrite S pulses", rises(obs_s), 1);
    chk("overwrite R pulses", rises(obs_r), 2);
    chk("overwrite last R rise", first_rise(obs_r, 12), 17);
    chk("overwrite Drop count", $countones(obs_d), 1);
    chk("overwrite QExp end", int'(obs_q[30]), 0);

    // Scenario 6: reset on the second clock of an S pulse.
    rp = '0; rp[8] = 1'b1;
    run_pat(mask(1, 40), 64'd0, rp, 25);
    chk("rst S before", int'(obs_s[7]), 1);
    chk("rst S after", int'(obs_s[8]), 0);
    chk("rst Busy after", int'(obs_b[8]), 0);
    chk("rst QExp after", int'(obs_q[8]), 0);
    chk("rst relaunch S rise", first_rise(obs_s, 8), 8 + DEB + 3);

    // Random levels with occasional glitches and resets.
    lvl_s = 0; lvl_c = 0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(7) == 0) lvl_s = ~lvl_s;
      if ($urandom_range(7) == 0) lvl_c = ~lvl_c;
      gs = lvl_s ^ ($urandom_range(15) == 0);
      gc = lvl_c ^ ($urandom_range(15) == 0);
      rr = ($urandom_range(199) == 0);
      step(rr, gs, gc);
    end

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
